fp_align_pipe: RTL

FP_ALIGN_PIPE -- requirements
Module: fp_align_pipe

---
 rtl/fp_pkg.sv | 29 ++
 rtl/fp_sticky_shift.sv | 33 +++
 rtl/fp_align_pipe.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/fp_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fp_pkg
//  Description : Shared definitions for the floating-point operand alignment
//                pipeline: default field widths, guard/round/sticky width and
//                the record describing one aligned operand pair.
//  Revision    : 1.0  initial release
// ============================================================================
package fp_pkg;

    localparam int FP_EXP_W = 8;                    // default exponent width
    localparam int FP_MAN_W = 24;                   // default mantissa width (hidden bit incl.)
    localparam int FP_GRS_W = 3;                    // guard, round, sticky
    localparam int FP_EXT_W = FP_MAN_W + FP_GRS_W;  // extended mantissa width

    // Aligned operand pair in the default (single-precision-like) format.
    typedef struct packed {
        logic                sign_big;
        logic                sign_small;
        logic [FP_EXP_W-1:0] exp;
        logic [FP_EXT_W-1:0] man_big;
        logic [FP_EXT_W-1:0] man_small;
        logic [FP_EXP_W-1:0] shift;
        logic                swapped;
        logic                eff_sub;
    } fp_align_t;

endpackage
`default_nettype wire

// File: rtl/fp_sticky_shift.sv
`default_nettype none
// ============================================================================
//  Module      : fp_sticky_shift
//  Description : Combinational logical right shift with sticky collection.
//                Every bit shifted out of x_i is ORed into the result LSB.
//  Ports       : x_i      extended mantissa {man, GRS}
//                shift_i  right-shift distance (unsaturated)
//                y_o      shifted value with sticky folded into bit 0
//  Revision    : 1.0  initial release
// ============================================================================
module fp_sticky_shift #(
    parameter int EXT_W = 27,
    parameter int EXP_W = 8
) (
    input  logic [EXT_W-1:0] x_i,
    input  logic [EXP_W-1:0] shift_i,
    output logic [EXT_W-1:0] y_o
);

    logic [EXT_W-1:0] shifted_w;
    logic [EXT_W-1:0] lost_mask_w;
    logic             sticky_w;

    // A shift distance of EXT_W or more empties the shifted value and turns
    // the mask into all ones, so the saturated case needs no separate branch:
    // the result collapses to {0..0, |x_i}.
    assign shifted_w   = x_i >> shift_i;
    assign lost_mask_w = ~({EXT_W{1'b1}} << shift_i);
    assign sticky_w    = |(x_i & lost_mask_w);
    assign y_o         = {shifted_w[EXT_W-1:1], shifted_w[0] | sticky_w};

endmodule
`default_nettype wire

// File: rtl/fp_align_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : fp_align_pipe
//  Description : Two-stage operand alignment for FP add/sub.
//                S1 compares magnitudes and swaps so the larger operand is
//                "big"; S2 right-shifts the smaller mantissa by the exponent
//                difference, keeping guard/round/sticky. Valid/ready on both
//                sides, 2-cycle latency, 1 pair/cycle throughput.
//  Ports       : clk, rst_n (async, active-low)
//                in_*   operand pair + in_valid/in_ready handshake
//                out_*  aligned result + out_valid/out_ready handshake
//  Revision    : 1.0  initial release
// ============================================================================
module fp_align_pipe
    import fp_pkg::*;
#(
    parameter int EXP_W = FP_EXP_W,
    parameter int MAN_W = FP_MAN_W
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic                        in_sign_a,
    input  logic                        in_sign_b,
    input  logic [EXP_W-1:0]            in_exp_a,
    input  logic [EXP_W-1:0]            in_exp_b,
    input  logic [MAN_W-1:0]            in_man_a,
    input  logic [MAN_W-1:0]            in_man_b,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic                        out_sign_big,
    output logic                        out_sign_small,
    output logic [EXP_W-1:0]            out_exp,
    output logic [MAN_W+FP_GRS_W-1:0]   out_man_big,
    output logic [MAN_W+FP_GRS_W-1:0]   out_man_small,
    output logic [EXP_W-1:0]            out_shift,
    output logic                        out_swapped,
    output logic                        out_eff_sub
);

    localparam int EXT_W = MAN_W + FP_GRS_W;

    // ---------------- handshake / stage enables ----------------
    logic s1_valid_q, s1_valid_d;
    logic s2_valid_q, s2_valid_d;
    logic s2_adv_w;     // S2 may take new content this cycle
    logic s1_load_w;    // S1 may take new content this cycle

    assign s2_adv_w  = !s2_valid_q || out_ready;
    assign in_ready  = !s1_valid_q || !s2_valid_q || out_ready;
    assign s1_load_w = in_ready;

    assign s1_valid_d = s1_load_w ? in_valid   : s1_valid_q;
    assign s2_valid_d = s2_adv_w  ? s1_valid_q : s2_valid_q;

    // ---------------- S1: compare and swap ----------------
    logic             a_big_w;
    logic             s1_sign_big_d,  s1_sign_big_q;
    logic             s1_sign_small_d, s1_sign_small_q;
    logic [EXP_W-1:0] s1_exp_d,       s1_exp_q;
    logic [MAN_W-1:0] s1_man_big_d,   s1_man_big_q;
    logic [MAN_W-1:0] s1_man_small_d, s1_man_small_q;
    logic [EXP_W-1:0] s1_shift_d,     s1_shift_q;
    logic             s1_swapped_d,   s1_swapped_q;
    logic             s1_eff_sub_d,   s1_eff_sub_q;

    // Ties (equal exponent and mantissa) keep a as the big operand.
    assign a_big_w = (in_exp_a > in_exp_b) ||
                     ((in_exp_a == in_exp_b) && (in_man_a >= in_man_b));

    always_comb begin
        s1_sign_big_d   = a_big_w ? in_sign_a : in_sign_b;
        s1_sign_small_d = a_big_w ? in_sign_b : in_sign_a;
        s1_exp_d        = a_big_w ? in_exp_a  : in_exp_b;
        s1_man_big_d    = a_big_w ? in_man_a  : in_man_b;
        s1_man_small_d  = a_big_w ? in_man_b  : in_man_a;
        s1_shift_d      = a_big_w ? (in_exp_a - in_exp_b) : (in_exp_b - in_exp_a);
        s1_swapped_d    = !a_big_w;
        s1_eff_sub_d    = in_sign_a ^ in_sign_b;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q      <= 1'b0;
            s1_sign_big_q   <= 1'b0;
            s1_sign_small_q <= 1'b0;
            s1_exp_q        <= '0;
            s1_man_big_q    <= '0;
            s1_man_small_q  <= '0;
            s1_shift_q      <= '0;
            s1_swapped_q    <= 1'b0;
            s1_eff_sub_q    <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            if (s1_load_w && in_valid) begin
                s1_sign_big_q   <= s1_sign_big_d;
                s1_sign_small_q <= s1_sign_small_d;
                s1_exp_q        <= s1_exp_d;
                s1_man_big_q    <= s1_man_big_d;
                s1_man_small_q  <= s1_man_small_d;
                s1_shift_q      <= s1_shift_d;
                s1_swapped_q    <= s1_swapped_d;
                s1_eff_sub_q    <= s1_eff_sub_d;
            end
        end
    end

    // ---------------- S2: shift and sticky ----------------
    logic [EXT_W-1:0] s2_man_big_d,   s2_man_big_q;
    logic [EXT_W-1:0] s2_man_small_d, s2_man_small_q;
    logic             s2_sign_big_q,  s2_sign_small_q;
    logic [EXP_W-1:0] s2_exp_q,       s2_shift_q;
    logic             s2_swapped_q,   s2_eff_sub_q;

    assign s2_man_big_d = {s1_man_big_q, {FP_GRS_W{1'b0}}};

    fp_sticky_shift #(
        .EXT_W (EXT_W),
        .EXP_W (EXP_W)
    ) u_sticky_shift (
        .x_i     ({s1_man_small_q, {FP_GRS_W{1'b0}}}),
        .shift_i (s1_shift_q),
        .y_o     (s2_man_small_d)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid_q      <= 1'b0;
            s2_sign_big_q   <= 1'b0;
            s2_sign_small_q <= 1'b0;
            s2_exp_q        <= '0;
            s2_man_big_q    <= '0;
            s2_man_small_q  <= '0;
            s2_shift_q      <= '0;
            s2_swapped_q    <= 1'b0;
            s2_eff_sub_q    <= 1'b0;
        end else begin
            s2_valid_q <= s2_valid_d;
            // Output data only moves when S2 advances, so it is frozen
            // while the downstream stalls.
            if (s2_adv_w && s1_valid_q) begin
                s2_sign_big_q   <= s1_sign_big_q;
                s2_sign_small_q <= s1_sign_small_q;
                s2_exp_q        <= s1_exp_q;
                s2_man_big_q    <= s2_man_big_d;
                s2_man_small_q  <= s2_man_small_d;
                s2_shift_q      <= s1_shift_q;
                s2_swapped_q    <= s1_swapped_q;
                s2_eff_sub_q    <= s1_eff_sub_q;
            end
        end
    end

    assign out_valid      = s2_valid_q;
    assign out_sign_big   = s2_sign_big_q;
    assign out_sign_small = s2_sign_small_q;
    assign out_exp        = s2_exp_q;
    assign out_man_big    = s2_man_big_q;
    assign out_man_small  = s2_man_small_q;
    assign out_shift      = s2_shift_q;
    assign out_swapped    = s2_swapped_q;
    assign out_eff_sub    = s2_eff_sub_q;

endmodule
`default_nettype wire
